btn_debounce: RTL and testbench

Tick-driven pushbutton front end for the sandbox board: synchronises one raw button pin, debounces it and classifies each press as a short click or a long press. It sits between the board pin and user logic, and shares the same single-cycle tick strobe convention as the LED blink blocks. Debounced level and single-cycle event pulses are registered outputs.

---
 rtl/btn_debounce.sv | 184 ++++++++++++++++++
 tb/tb_btn_debounce.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises, debounces and classifies one pushbutton pin.
// Ports: clk, rst (sync, active-high), tick (1-cycle strobe), btn_raw (async pin)
//        -> level (debounced pressed), press, released, click, long_press (1-cycle pulses).
// Optional auto-repeat of long_press: define BTN_DEBOUNCE_REPEAT_EN.
`timescale 1ns/1ps
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic released,
    output logic click,
    output logic long_press
);

    localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int DW   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);
`endif

    // Pin level when the button is not pressed.
    localparam logic IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        PRESSED,
        LONG_HELD,
        RELEASE_DB
    } state_t;

    state_t        state, state_n;
    logic          sync1, sync2;
    logic          p;
    logic [DW-1:0] db_cnt, db_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic          long_flag, flag_n;
    logic          level_n, press_n, rel_n, click_n, long_n;

    // Normalised pressed state: 1 = pressed regardless of pin polarity.
    assign p = sync2 ^ IDLE_PIN;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= IDLE_PIN;
            sync2      <= IDLE_PIN;
            state      <= IDLE;
            db_cnt     <= '0;
            hold_cnt   <= '0;
            long_flag  <= 1'b0;
            level      <= 1'b0;
            press      <= 1'b0;
            released   <= 1'b0;
            click      <= 1'b0;
            long_press <= 1'b0;
        end else begin
            sync1      <= btn_raw;
            sync2      <= sync1;
            state      <= state_n;
            db_cnt     <= db_n;
            hold_cnt   <= hold_n;
            long_flag  <= flag_n;
            level      <= level_n;
            press      <= press_n;
            released   <= rel_n;
            click      <= click_n;
            long_press <= long_n;
        end
    end

    always_comb begin
        state_n = state;
        db_n    = db_cnt;
        hold_n  = hold_cnt;
        flag_n  = long_flag;
        level_n = level;
        press_n = 1'b0;
        rel_n   = 1'b0;
        click_n = 1'b0;
        long_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (p) begin
                    state_n = PRESS_DB;
                    db_n    = '0;
                end
            end

            // A mismatch always takes priority over a coincident tick.
            PRESS_DB: begin
                if (!p) begin
                    state_n = IDLE;
                    db_n    = '0;
                end else if (tick) begin
                    if (db_cnt == DB_LAST) begin
                        state_n = PRESSED;
                        db_n    = '0;
                        hold_n  = '0;
                        press_n = 1'b1;
                        level_n = 1'b1;
                    end else begin
                        db_n = db_cnt + 1'b1;
                    end
                end
            end

            PRESSED: begin
                if (!p) begin
                    state_n = RELEASE_DB;
                    db_n    = '0;
                end else if (tick) begin
                    if (hold_cnt == LONG_LAST) begin
                        state_n = LONG_HELD;
                        long_n  = 1'b1;
                        flag_n  = 1'b1;
`ifdef BTN_DEBOUNCE_REPEAT_EN
                        hold_n  = '0;
`else
                        hold_n  = hold_cnt + 1'b1;
`endif
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
            end

            // Without repeat the hold counter simply parks at LONG_TICKS.
            LONG_HELD: begin
                if (!p) begin
                    state_n = RELEASE_DB;
                    db_n    = '0;
                end
`ifdef BTN_DEBOUNCE_REPEAT_EN
                else if (tick) begin
                    if (hold_cnt == REP_LAST) begin
                        long_n = 1'b1;
                        hold_n = '0;
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
`endif
            end

            // Hold counter is frozen here so a bounce-back resumes it.
            RELEASE_DB: begin
                if (p) begin
                    state_n = long_flag ? LONG_HELD : PRESSED;
                    db_n    = '0;
                end else if (tick) begin
                    if (db_cnt == DB_LAST) begin
                        state_n = IDLE;
                        db_n    = '0;
                        rel_n   = 1'b1;
                        click_n = ~long_flag;
                        level_n = 1'b0;
                        flag_n  = 1'b0;
                    end else begin
                        db_n = db_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                db_n    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed table + scenario bench for btn_debounce.
// DEBOUNCE_TICKS=4, LONG_TICKS=50, REPEAT_TICKS=10, active-low pin.
`timescale 1ns/1ps
module tb_btn_debounce;

    localparam int DB = 4;
    localparam int LT = 50;
    localparam int RT = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic btn_raw = 1'b1;
    logic level, press, released, click, long_press;
    logic [4:0] outs;

    assign outs = {level, press, released, click, long_press};

    always #5 clk = ~clk;

    btn_debounce #(
        .DEBOUNCE_TICKS(DB),
        .LONG_TICKS(LT),
        .REPEAT_TICKS(RT),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .btn_raw(btn_raw),
        .level(level),
        .press(press),
        .released(released),
        .click(click),
        .long_press(long_press)
    );

    typedef struct packed {
        logic       r;
        logic       raw;
        logic       tk;
        logic [4:0] e;
    } vec_t;

    vec_t tv[$];

    int n_chk = 0;
    int n_fail = 0;
    int tick_n = 0;
    int press_cnt, rel_cnt, click_cnt, long_cnt;
    int press_t, rel_t, click_t;
    int long_t[$];

    task automatic add(input int n, input logic r, input logic raw,
                       input logic tk, input logic [4:0] e);
        vec_t v;
        v.r = r;
        v.raw = raw;
        v.tk = tk;
        v.e = e;
        for (int i = 0; i < n; i++) tv.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_log();
        press_cnt = 0;
        rel_cnt = 0;
        click_cnt = 0;
        long_cnt = 0;
        press_t = -1;
        rel_t = -1;
        click_t = -1;
        long_t.delete();
    endtask

    // One clock: drive inputs, take the edge, sample 1ns later and log pulses.
    task automatic cyc(input logic raw, input logic tk, input logic r);
        btn_raw = raw;
        tick = tk;
        rst = r;
        @(posedge clk);
        #1;
        if (tk) tick_n++;
        if (press === 1'b1) begin press_cnt++; press_t = tick_n; end
        if (released === 1'b1) begin rel_cnt++; rel_t = tick_n; end
        if (click === 1'b1) begin click_cnt++; click_t = tick_n; end
        if (long_press === 1'b1) begin long_cnt++; long_t.push_back(tick_n); end
    endtask

    task automatic period(input logic raw);
        cyc(raw, 1'b1, 1'b0);
        repeat (9) cyc(raw, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b1);
        repeat (3) period(1'b1);
        clr_log();
    endtask

    int t0, tr, exp_n;

    initial begin
        clr_log();

        // Per-cycle vectors with tick held high; e = {level,press,rel,click,long}.
        add(1, 1, 1, 1, 5'b00000);
        add(1, 0, 1, 1, 5'b00000);
        add(6, 0, 0, 1, 5'b00000);
        add(1, 0, 0, 1, 5'b11000);
        add(1, 0, 0, 1, 5'b10000);
        add(6, 0, 1, 1, 5'b10000);
        add(1, 0, 1, 1, 5'b00110);
        add(1, 0, 1, 1, 5'b00000);
        add(4, 0, 0, 1, 5'b00000);
        add(4, 0, 1, 1, 5'b00000);
        add(3, 0, 0, 0, 5'b00000);
        add(3, 0, 0, 1, 5'b00000);
        add(2, 0, 0, 0, 5'b00000);
        add(1, 0, 0, 1, 5'b11000);
        add(1, 0, 0, 0, 5'b10000);
        add(1, 1, 0, 1, 5'b00000);
        add(6, 0, 0, 1, 5'b00000);
        add(1, 0, 0, 1, 5'b11000);
        add(1, 0, 0, 1, 5'b10000);

        for (int i = 0; i < tv.size(); i++) begin
            cyc(tv[i].raw, tv[i].tk, tv[i].r);
            check($sformatf("vec%0d", i), int'(outs), int'(tv[i].e));
        end

        // Clean short press, 20 ticks.
        do_reset();
        t0 = tick_n + 1;
        repeat (20) period(1'b0);
        check("short_level_held", int'(level), 1);
        tr = tick_n + 1;
        repeat (8) period(1'b1);
        check("short_press_cnt", press_cnt, 1);
        check("short_press_t", press_t, t0 + DB);
        check("short_rel_cnt", rel_cnt, 1);
        check("short_rel_t", rel_t, tr + DB);
        check("short_click_cnt", click_cnt, 1);
        check("short_click_t", click_t, rel_t);
        check("short_long_cnt", long_cnt, 0);
        check("short_level_off", int'(level), 0);

        // Bounce: toggle every 3 cycles for 5 ticks, then settle pressed.
        do_reset();
        for (int c = 0; c < 50; c++)
            cyc(((c / 3) % 2) == 0, (c % 10) == 0, 1'b0);
        check("bounce_quiet", press_cnt + rel_cnt + click_cnt + long_cnt, 0);
        t0 = tick_n + 1;
        repeat (8) period(1'b0);
        check("bounce_press_cnt", press_cnt, 1);
        check("bounce_press_t", press_t, t0 + DB);

        // Long press held 80 ticks past press.
        do_reset();
        t0 = tick_n + 1;
        repeat (85) period(1'b0);
        tr = tick_n + 1;
        repeat (8) period(1'b1);
`ifdef BTN_DEBOUNCE_REPEAT_EN
        exp_n = 4;
`else
        exp_n = 1;
`endif
        check("long_cnt", long_cnt, exp_n);
        for (int i = 0; i < long_t.size() && i < exp_n; i++)
            check($sformatf("long_t%0d", i), long_t[i], t0 + DB + LT + i * RT);
        check("long_rel_cnt", rel_cnt, 1);
        check("long_rel_t", rel_t, tr + DB);
        check("long_click_cnt", click_cnt, 0);

        // Release glitch at hold count ~30: 2-tick release then re-press.
        do_reset();
        t0 = tick_n + 1;
        repeat (35) period(1'b0);
        repeat (2) period(1'b1);
        repeat (23) period(1'b0);
        check("glitch_rel_cnt", rel_cnt, 0);
        check("glitch_long_cnt", long_cnt, 1);
        if (long_t.size() > 0)
            check("glitch_long_t", long_t[0], t0 + 56);
        else
            check("glitch_long_t", -1, t0 + 56);
        repeat (6) period(1'b1);
        check("glitch_end_rel", rel_cnt, 1);
        check("glitch_end_click", click_cnt, 0);

        // Reset while in LONG_HELD, button still held.
        do_reset();
        repeat (56) period(1'b0);
        check("rst_pre_long", long_cnt, 1);
        check("rst_pre_level", int'(level), 1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check("rst_outs_zero", int'(outs), 0);
        clr_log();
        tr = tick_n;
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        check("rst_no_pulse", rel_cnt + click_cnt + press_cnt, 0);
        repeat (1) cyc(1'b0, 1'b0, 1'b0);
        repeat (6) period(1'b0);
        check("rst_press_cnt", press_cnt, 1);
        check("rst_press_t", press_t, tr + DB);
        check("rst_rel_cnt", rel_cnt + click_cnt, 0);
        check("rst_level", int'(level), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
